// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    // Unsigned magnitude of a two's complement value; 0x80000000 maps to itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/add_sub32.sv
// Combinational 32-bit adder/subtractor; carry is the no-borrow flag when subtracting.
module add_sub32
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full;

    assign full         = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
    assign {carry, sum} = full;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply (shift-add) / divide (restoring) unit.
// One iteration per cycle on operand magnitudes, sign fix-up in the DONE state.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    state_t               state, next_state;
    op_t                  op;
    op_t                  start_op;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_iter;
    logic [WIDTH-1:0]     opnd_mag;
    logic                 sign_a, sign_b;
    logic                 start;

    logic [WIDTH-1:0]     add_a, add_sum;
    logic                 add_carry;

    logic                 negate;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     fix_result;
    logic                 fix_exc;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign start_op = ctrl_MULT ? OP_MULT : OP_DIV;
    assign busy     = (state != IDLE);

    // Multiply accumulates into the upper word; divide trial-subtracts the shifted remainder.
    assign add_a = (op == OP_MULT) ? acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-2:WIDTH-1];

    add_sub32 u_add_sub (
        .a     (add_a),
        .b     (opnd_mag),
        .sub   (op == OP_DIV),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        acc_iter = acc;
        if (op == OP_MULT) begin
            if (acc[0]) acc_iter = {add_carry, add_sum, acc[WIDTH-1:1]};
            else        acc_iter = {1'b0, acc[2*WIDTH-1:1]};
        end else begin
            if (add_carry) acc_iter = {add_sum, acc[WIDTH-2:0], 1'b1};
            else           acc_iter = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        negate     = sign_a ^ sign_b;
        prod       = negate ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
        quot       = negate ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[WIDTH-1:0];
        fix_result = '0;
        fix_exc    = 1'b0;
        if (op == OP_MULT) begin
            fix_result = prod[WIDTH-1:0];
            fix_exc    = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &&
                         (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
        end else if (opnd_mag == '0) begin
            fix_result = '0;
            fix_exc    = 1'b1;
        end else begin
            // A positive quotient with bit 31 set only arises from 0x80000000 / -1.
            fix_result = quot;
            fix_exc    = ~negate & acc[WIDTH-1];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN: begin
                if (start)                                 next_state = RUN;
                else if (cnt == CNT_W'(ITER_COUNT - 1))    next_state = DONE;
            end
            DONE: begin
                if (start)               next_state = RUN;
                else if (data_resultRDY) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // DONE spans two cycles: the first registers the result, the second presents RDY.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op             <= OP_MULT;
            cnt            <= '0;
            acc            <= '0;
            opnd_mag       <= '0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                op       <= start_op;
                cnt      <= '0;
                acc      <= {{WIDTH{1'b0}}, magnitude(data_operandA)};
                opnd_mag <= magnitude(data_operandB);
                sign_a   <= data_operandA[WIDTH-1];
                sign_b   <= data_operandB[WIDTH-1];
            end else begin
                case (state)
                    RUN: begin
                        acc <= acc_iter;
                        cnt <= cnt + CNT_W'(1);
                    end
                    DONE: begin
                        if (!data_resultRDY) begin
                            data_result    <= fix_result;
                            data_exception <= fix_exc;
                            data_resultRDY <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed starts push expectations, a monitor checks RDY.
module tb_multdiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] opa, opb;
    logic [31:0] result;
    logic        exc, rdy, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clk),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_mult),
        .ctrl_DIV       (ctrl_div),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        if (resetn === 1'b1 && rdy === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 32'(rdy), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_exc"}, 32'(exc), 32'(e.exc));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    // Start is sampled at the edge following the negedge where it is driven.
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee, input string name, input bit flush);
        exp_t e;
        @(negedge clk);
        ctrl_mult = m;
        ctrl_div  = d;
        opa       = a;
        opb       = b;
        if (flush) sb.delete();
        e.res  = er;
        e.exc  = ee;
        e.due  = cyc + 1 + 33;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        opa       = $urandom;
        opb       = $urandom;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        resetn    = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        opa       = '0;
        opb       = '0;
        #22;
        check("reset_result", result, 32'd0);
        check("reset_exc", 32'(exc), 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 7 * -3 with busy window checked cycle by cycle
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3", 1'b0);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 33) check("busy_high", 32'(busy), 32'd1);
            if (k == 34) begin
                check("busy_low_after", 32'(busy), 32'd0);
                check("rdy_low_after", 32'(rdy), 32'd0);
            end
        end
        drain();

        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf", 1'b0);
        drain();
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2", 1'b0);
        drain();
        issue(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero", 1'b0);
        drain();

        // Abort: MULT at T is replaced by DIV at T+10
        issue(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, "mul_aborted", 1'b0);
        repeat (9) @(posedge clk);
        issue(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, "div_100_7", 1'b1);
        drain();

        issue(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, "both_ctrl", 1'b0);
        drain();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1", 1'b0);
        drain();
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min_m1", 1'b0);
        drain();
        issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, "div_m100_7", 1'b0);
        drain();
        issue(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1, "mul_ffff_sq", 1'b0);
        drain();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min_1", 1'b0);
        drain();
        issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0, "mul_m5_m6", 1'b0);
        drain();

        // Reset during a multiply: outputs clear at once and no RDY follows
        issue(1'b1, 1'b0, 32'd2, 32'd3, 32'd6, 1'b0, "mul_reset", 1'b0);
        repeat (14) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        sb.delete();
        check("midrst_result", result, 32'd0);
        check("midrst_exc", 32'(exc), 32'd0);
        check("midrst_rdy", 32'(rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        issue(1'b0, 1'b1, 32'd9, 32'd3, 32'd3, 1'b0, "div_9_3", 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
